mac_vec_engine: RTL and testbench
=================================

// Module: mac_vec_engine
// PURPOSE
//  N-lane signed vector MAC engine; next-generation HWPE MAC datapath.
//  Consumes joined a/b operand streams, accumulates len_i dot-product beats per lane, adds a c bias
//  vector, shifts and emits one d vector. The streamer drives it; the ctrl FSM programs it via start_i.
//  Adds a per-beat multiply mode, configurable normalisation shift and optional output saturation.
// PARAMETERS
//  N_LANES  4   parallel lanes (one operand pair per lane per beat)
//  IN_W     16  signed operand width (a, b)
//  ACC_W    40  signed accumulator width; must satisfy ACC_W >= 2*IN_W
//  OUT_W    32  signed bias/result width (c, d); must satisfy OUT_W <= ACC_W
// PORTS
//  clk_i        in   1              clock
//  rst_i        in   1              synchronous reset, active-high
//  clear_i      in   1              synchronous soft clear (same effect as rst_i)
//  start_i      in   1              start job; ignored unless busy_o=0
//  len_i        in   16             beats per accumulation (mode 0) or outputs per job (mode 1)
//  shift_i      in   6              arithmetic right shift applied before output
//  mode_i       in   1              0=accumulate+bias, 1=per-beat product (c unused)
//  a_valid_i/a_ready_o in/out 1     a stream handshake
//  a_data_i     in   N_LANES*IN_W   lane k at [k*IN_W +: IN_W]
//  b_valid_i/b_ready_o in/out 1     b stream handshake
//  b_data_i     in   N_LANES*IN_W
//  c_valid_i/c_ready_o in/out 1     bias stream handshake
//  c_data_i     in   N_LANES*OUT_W
//  d_valid_o/d_ready_i out/in 1     result stream handshake
//  d_data_o     out  N_LANES*OUT_W
//  busy_o       out  1              state != IDLE
//  done_o       out  1              one-cycle pulse when the job's last d beat handshakes
//  cnt_o        out  16             beats consumed in current accumulation / outputs sent in mode 1
// BEHAVIOUR
//  Reset/clear: state=IDLE, all accumulators, cnt_o, latched config = 0; every output 0.
//  clear_i mid-job aborts to IDLE next cycle, no done_o; in-flight beats are dropped.
//  start_i in IDLE latches len_i, shift_i, mode_i (clamped to ACC_W-1 if shift_i >= ACC_W),
//    zeroes accumulators and cnt_o, goes to ACCUM; start_i while busy is ignored.
//  FSM: IDLE -> ACCUM -> (mode0: BIAS) -> OUT -> IDLE | ACCUM.
//  ACCUM: a_ready_o=b_valid_i, b_ready_o=a_valid_i (joined: a beat fires only if both valid);
//    one beat per cycle max; acc_k += sext(a_k*b_k), product 2*IN_W signed, acc wraps modulo 2^ACC_W.
//    Mode 0: after the len-th beat -> BIAS next cycle; len=0 -> BIAS directly from start, acc=0.
//    Mode 1: each beat loads acc_k=product -> OUT next cycle; len=0 -> IDLE and done_o pulse.
//  BIAS: c_ready_o=1; on c handshake r_k=(acc_k>>>shift)+sext(c_k) in ACC_W+1 bits -> OUT next cycle.
//  OUT: d_valid_o=1 and d_data_o held stable until d_ready_i; on handshake:
//    mode 0 -> IDLE, done_o; mode 1 -> ACCUM, cnt_o+1, or IDLE+done_o if cnt_o reaches len.
//  Mode 1 output r_k = acc_k>>>shift. All ready outputs 0 outside their state.
//  Throughput: mode 0 len+2 cycles + stalls; mode 1 two cycles per output.
// CONFIGURATION
//  MAC_VEC_ENGINE_SAT_EN defined: r_k saturated to [-2^(OUT_W-1), 2^(OUT_W-1)-1] on the way to d.
//  Undefined: r_k truncated to low OUT_W bits (two's-complement wrap). No other difference.
// STRUCTURE
//  mac_vec_package: state enum (IDLE/ACCUM/BIAS/OUT), mac_vec_cfg_t {len, shift, mode},
//    localparam defaults, function sat_trunc(r) shared with the ctrl side for model reuse.
//  Sub-module mac_vec_lane (x N_LANES via generate): accumulator, shift, bias add, sat/trunc;
//    top holds FSM, counter, handshakes and config latch.
// TESTING
//  1 Mode0 len=3, shift=0, a=b={1,2,3,4} x3, c={10,10,10,10} -> d={13,22,37,58}, done_o 1 cycle.
//  2 Mode0 len=2, a valid stalled 3 cycles, d_ready_i low 4 cycles -> d held stable, same result, no loss.
//  3 Mode1 len=2, shift=2, a={8,-8,4,0},b={2,2,2,2} then a=b={-1,...} -> d={4,-4,2,0} then {0,0,0,0}.
//  4 Mode0 a=b=32767 len=4, c=0 -> SAT_EN: d=2147483647 per lane; else low 32 bits (0xFFFC0004).
//  5 clear_i during ACCUM after 1 beat, then start len=1, a=b=c={1,...} -> d={2,...}, no stale acc.
//  6 start_i while busy and len=0 mode0 with c={-5,...} -> ignored; then d={-5,...} with done_o.

Source files
------------

// File: rtl/mac_vec_engine_pkg.sv
// Shared types, reset defaults and the saturate/truncate helper for the MAC vector engine.
// Build option: MAC_VEC_ENGINE_SAT_EN selects saturation instead of wrap in sat_trunc.
package mac_vec_package;

    localparam int unsigned N_LANES_D = 4;
    localparam int unsigned IN_W_D    = 16;
    localparam int unsigned ACC_W_D   = 40;
    localparam int unsigned OUT_W_D   = 32;
    localparam int unsigned LEN_W     = 16;
    localparam int unsigned SHIFT_W   = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        BIAS  = 2'd2,
        OUT   = 2'd3
    } mac_vec_state_e;

    typedef struct packed {
        logic [LEN_W-1:0]   len;
        logic [SHIFT_W-1:0] shift;
        logic               mode;
    } mac_vec_cfg_t;

    localparam mac_vec_cfg_t CFG_RESET = '{len: '0, shift: '0, mode: 1'b0};

    // Result is returned sign-extended to 64 bits; callers keep the low out_w bits.
    function automatic logic signed [63:0] sat_trunc(input logic signed [63:0] r,
                                                     input int unsigned      out_w);
        logic signed [63:0] res;
`ifdef MAC_VEC_ENGINE_SAT_EN
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (out_w - 1));
        if (r > hi) begin
            res = hi;
        end else if (r < lo) begin
            res = lo;
        end else begin
            res = r;
        end
`else
        res = (r <<< (64 - out_w)) >>> (64 - out_w);
`endif
        return res;
    endfunction

endpackage

// File: rtl/mac_vec_engine_lane.sv
// One MAC lane: signed multiply, wrapping accumulator, normalisation shift, bias add and
// saturate/truncate into a held result register.
module mac_vec_lane
    import mac_vec_package::*;
#(
    parameter int unsigned IN_W  = IN_W_D,
    parameter int unsigned ACC_W = ACC_W_D,
    parameter int unsigned OUT_W = OUT_W_D
) (
    input  logic                     clk,
    input  logic                     srst,
    input  logic                     acc_clr,
    input  logic                     beat,
    input  logic                     mode,
    input  logic [SHIFT_W-1:0]       shift,
    input  logic                     bias_fire,
    input  logic signed [IN_W-1:0]   a,
    input  logic signed [IN_W-1:0]   b,
    input  logic signed [OUT_W-1:0]  c,
    output logic signed [OUT_W-1:0]  d
);

    logic signed [2*IN_W-1:0] prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  acc_sh;
    logic signed [ACC_W-1:0]  prod_sh;
    logic signed [ACC_W:0]    biased;

    assign prod     = a * b;
    assign prod_ext = ACC_W'(prod);
    assign acc_sh   = acc >>> shift;
    assign prod_sh  = prod_ext >>> shift;
    assign biased   = (ACC_W+1)'(acc_sh) + (ACC_W+1)'(c);

    // Per-beat mode computes d straight from the product so OUT can follow the beat directly.
    always_ff @(posedge clk) begin
        if (srst) begin
            acc <= '0;
            d   <= '0;
        end else begin
            if (acc_clr) begin
                acc <= '0;
            end else if (beat) begin
                acc <= mode ? prod_ext : acc + prod_ext;
            end
            if (bias_fire) begin
                d <= OUT_W'(sat_trunc(64'(biased), OUT_W));
            end else if (beat && mode) begin
                d <= OUT_W'(sat_trunc(64'(prod_sh), OUT_W));
            end
        end
    end

endmodule

// File: rtl/mac_vec_engine.sv
// N-lane signed vector MAC engine top: job FSM, beat/output counter, stream handshakes, config latch.
// Build option: MAC_VEC_ENGINE_SAT_EN saturates results to OUT_W instead of wrapping.
module mac_vec_engine
    import mac_vec_package::*;
#(
    parameter int unsigned N_LANES = N_LANES_D,
    parameter int unsigned IN_W    = IN_W_D,
    parameter int unsigned ACC_W   = ACC_W_D,
    parameter int unsigned OUT_W   = OUT_W_D
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clear_i,
    input  logic                     start_i,
    input  logic [15:0]              len_i,
    input  logic [5:0]               shift_i,
    input  logic                     mode_i,
    input  logic                     a_valid_i,
    output logic                     a_ready_o,
    input  logic [N_LANES*IN_W-1:0]  a_data_i,
    input  logic                     b_valid_i,
    output logic                     b_ready_o,
    input  logic [N_LANES*IN_W-1:0]  b_data_i,
    input  logic                     c_valid_i,
    output logic                     c_ready_o,
    input  logic [N_LANES*OUT_W-1:0] c_data_i,
    output logic                     d_valid_o,
    input  logic                     d_ready_i,
    output logic [N_LANES*OUT_W-1:0] d_data_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic [15:0]              cnt_o
);

    mac_vec_state_e     state, state_nxt;
    mac_vec_cfg_t       cfg, cfg_nxt;
    logic [LEN_W-1:0]   cnt, cnt_nxt;
    logic [SHIFT_W-1:0] shift_clamped;
    logic               srst;
    logic               acc_clr;
    logic               beat;
    logic               bias_fire;

    assign srst          = rst_i | clear_i;
    assign shift_clamped = (32'(shift_i) >= ACC_W) ? SHIFT_W'(ACC_W - 1) : shift_i;

    always_ff @(posedge clk_i) begin
        if (srst) begin
            state <= IDLE;
            cfg   <= CFG_RESET;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cfg   <= cfg_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cfg_nxt   = cfg;
        cnt_nxt   = cnt;
        a_ready_o = 1'b0;
        b_ready_o = 1'b0;
        c_ready_o = 1'b0;
        d_valid_o = 1'b0;
        done_o    = 1'b0;
        acc_clr   = 1'b0;
        beat      = 1'b0;
        bias_fire = 1'b0;

        case (state)
            IDLE: begin
                if (start_i) begin
                    cfg_nxt.len   = len_i;
                    cfg_nxt.shift = shift_clamped;
                    cfg_nxt.mode  = mode_i;
                    cnt_nxt       = '0;
                    acc_clr       = 1'b1;
                    state_nxt     = (!mode_i && len_i == '0) ? BIAS : ACCUM;
                end
            end
            ACCUM: begin
                // An empty per-beat job passes through ACCUM once, accepting no beat, to signal done.
                if (cfg.mode && cfg.len == '0) begin
                    state_nxt = IDLE;
                    done_o    = 1'b1;
                end else begin
                    a_ready_o = b_valid_i;
                    b_ready_o = a_valid_i;
                    beat      = a_valid_i && b_valid_i;
                    if (beat) begin
                        if (!cfg.mode) begin
                            cnt_nxt = cnt + 1'b1;
                            if (cnt_nxt == cfg.len) begin
                                state_nxt = BIAS;
                            end
                        end else begin
                            state_nxt = OUT;
                        end
                    end
                end
            end
            BIAS: begin
                c_ready_o = 1'b1;
                if (c_valid_i) begin
                    bias_fire = 1'b1;
                    state_nxt = OUT;
                end
            end
            OUT: begin
                d_valid_o = 1'b1;
                if (d_ready_i) begin
                    if (!cfg.mode) begin
                        state_nxt = IDLE;
                        done_o    = 1'b1;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                        if (cnt_nxt == cfg.len) begin
                            state_nxt = IDLE;
                            done_o    = 1'b1;
                        end else begin
                            state_nxt = ACCUM;
                        end
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (clear_i) begin
            done_o = 1'b0;
        end
    end

    assign busy_o = (state != IDLE);
    assign cnt_o  = cnt;

    for (genvar k = 0; k < N_LANES; k++) begin : g_lane
        mac_vec_lane #(
            .IN_W  (IN_W),
            .ACC_W (ACC_W),
            .OUT_W (OUT_W)
        ) u_lane (
            .clk       (clk_i),
            .srst      (srst),
            .acc_clr   (acc_clr),
            .beat      (beat),
            .mode      (cfg.mode),
            .shift     (cfg.shift),
            .bias_fire (bias_fire),
            .a         (a_data_i[k*IN_W +: IN_W]),
            .b         (b_data_i[k*IN_W +: IN_W]),
            .c         (c_data_i[k*OUT_W +: OUT_W]),
            .d         (d_data_o[k*OUT_W +: OUT_W])
        );
    end

endmodule

// File: tb/tb_mac_vec_engine.sv
// Directed-vector bench for mac_vec_engine with hand-computed expected d vectors.
module tb_mac_vec_engine;

    localparam int unsigned NL = 4;
    localparam int unsigned IW = 16;
    localparam int unsigned OW = 32;

    logic              clk = 1'b0;
    logic              rst_i, clear_i, start_i, mode_i;
    logic [15:0]       len_i;
    logic [5:0]        shift_i;
    logic              a_valid_i, a_ready_o, b_valid_i, b_ready_o;
    logic              c_valid_i, c_ready_o, d_valid_o, d_ready_i;
    logic [NL*IW-1:0]  a_data_i, b_data_i;
    logic [NL*OW-1:0]  c_data_i, d_data_o;
    logic              busy_o, done_o;
    logic [15:0]       cnt_o;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mac_vec_engine #(.N_LANES(NL), .IN_W(IW), .ACC_W(40), .OUT_W(OW)) dut (
        .clk_i(clk), .rst_i(rst_i), .clear_i(clear_i), .start_i(start_i),
        .len_i(len_i), .shift_i(shift_i), .mode_i(mode_i),
        .a_valid_i(a_valid_i), .a_ready_o(a_ready_o), .a_data_i(a_data_i),
        .b_valid_i(b_valid_i), .b_ready_o(b_ready_o), .b_data_i(b_data_i),
        .c_valid_i(c_valid_i), .c_ready_o(c_ready_o), .c_data_i(c_data_i),
        .d_valid_o(d_valid_o), .d_ready_i(d_ready_i), .d_data_o(d_data_o),
        .busy_o(busy_o), .done_o(done_o), .cnt_o(cnt_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [NL*IW-1:0] pk_in(input int v0, input int v1, input int v2, input int v3);
        logic [NL*IW-1:0] r;
        int v[4];
        v = '{v0, v1, v2, v3};
        for (int k = 0; k < 4; k++) r[k*IW +: IW] = IW'(v[k]);
        return r;
    endfunction

    function automatic logic [NL*OW-1:0] pk_out(input int v0, input int v1, input int v2, input int v3);
        logic [NL*OW-1:0] r;
        int v[4];
        v = '{v0, v1, v2, v3};
        for (int k = 0; k < 4; k++) r[k*OW +: OW] = OW'(v[k]);
        return r;
    endfunction

    task automatic start_job(input int len, input int shift, input logic mode);
        @(negedge clk);
        start_i = 1'b1;
        len_i   = 16'(len);
        shift_i = 6'(shift);
        mode_i  = mode;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic send_beat(input logic [NL*IW-1:0] a, input logic [NL*IW-1:0] b, input int a_stall);
        int t = 0;
        a_data_i  = a;
        b_data_i  = b;
        b_valid_i = 1'b1;
        a_valid_i = 1'b0;
        for (int i = 0; i < a_stall; i++) begin
            #1;
            check("stall_b_ready", b_ready_o, 1'b0);
            @(negedge clk);
        end
        a_valid_i = 1'b1;
        #1;
        while (!(a_ready_o && b_ready_o) && t < 50) begin
            @(negedge clk);
            #1;
            t++;
        end
        check("beat_ready", a_ready_o && b_ready_o, 1'b1);
        @(negedge clk);
        a_valid_i = 1'b0;
        b_valid_i = 1'b0;
    endtask

    task automatic send_c(input logic [NL*OW-1:0] c);
        int t = 0;
        c_data_i  = c;
        c_valid_i = 1'b1;
        #1;
        while (!c_ready_o && t < 50) begin
            @(negedge clk);
            #1;
            t++;
        end
        check("c_ready", c_ready_o, 1'b1);
        @(negedge clk);
        c_valid_i = 1'b0;
    endtask

    task automatic recv_d(input logic [NL*OW-1:0] exp, input int hold, input logic last);
        int t = 0;
        #1;
        while (!d_valid_o && t < 50) begin
            @(negedge clk);
            #1;
            t++;
        end
        check("d_valid", d_valid_o, 1'b1);
        for (int i = 0; i < hold; i++) begin
            for (int k = 0; k < NL; k++) check("d_hold", d_data_o[k*OW +: OW], exp[k*OW +: OW]);
            check("d_hold_valid", d_valid_o, 1'b1);
            @(negedge clk);
            #1;
        end
        d_ready_i = 1'b1;
        #1;
        for (int k = 0; k < NL; k++) check("d_data", d_data_o[k*OW +: OW], exp[k*OW +: OW]);
        check("done_at_hs", done_o, last);
        @(negedge clk);
        d_ready_i = 1'b0;
        #1;
        check("done_pulse_end", done_o, 1'b0);
    endtask

    initial begin
        rst_i = 1'b1; clear_i = 1'b0; start_i = 1'b0; mode_i = 1'b0;
        len_i = '0; shift_i = '0;
        a_valid_i = 1'b0; b_valid_i = 1'b0; c_valid_i = 1'b0; d_ready_i = 1'b0;
        a_data_i = '0; b_data_i = '0; c_data_i = '0;
        repeat (2) @(negedge clk);
        rst_i = 1'b0;
        #1;
        check("rst_busy", busy_o, 1'b0);
        check("rst_cnt", cnt_o, 16'd0);
        check("rst_d_valid", d_valid_o, 1'b0);
        check("rst_a_ready", a_ready_o, 1'b0);
        check("rst_d_data", d_data_o[63:0], 64'd0);

        // 1: mode 0, len 3, bias 10
        start_job(3, 0, 1'b0);
        for (int i = 0; i < 3; i++) send_beat(pk_in(1, 2, 3, 4), pk_in(1, 2, 3, 4), 0);
        #1;
        check("t1_cnt", cnt_o, 16'd3);
        check("t1_busy", busy_o, 1'b1);
        send_c(pk_out(10, 10, 10, 10));
        recv_d(pk_out(13, 22, 37, 58), 0, 1'b1);
        check("t1_idle", busy_o, 1'b0);

        // 2: a stalls and d back-pressure
        start_job(2, 0, 1'b0);
        send_beat(pk_in(1, 2, 3, 4), pk_in(5, 6, 7, 8), 3);
        #1;
        check("t2_cnt1", cnt_o, 16'd1);
        send_beat(pk_in(1, 2, 3, 4), pk_in(5, 6, 7, 8), 0);
        send_c(pk_out(1, 1, 1, 1));
        recv_d(pk_out(11, 25, 43, 65), 4, 1'b1);

        // 3: mode 1, len 2, shift 2
        start_job(2, 2, 1'b1);
        send_beat(pk_in(8, -8, 4, 0), pk_in(2, 2, 2, 2), 0);
        recv_d(pk_out(4, -4, 2, 0), 0, 1'b0);
        check("t3_cnt1", cnt_o, 16'd1);
        send_beat(pk_in(-1, -1, -1, -1), pk_in(-1, -1, -1, -1), 0);
        recv_d(pk_out(0, 0, 0, 0), 0, 1'b1);
        check("t3_idle", busy_o, 1'b0);

        // 4: overflow past OUT_W
        start_job(4, 0, 1'b0);
        for (int i = 0; i < 4; i++) send_beat(pk_in(32767, 32767, 32767, 32767), pk_in(32767, 32767, 32767, 32767), 0);
        send_c(pk_out(0, 0, 0, 0));
`ifdef MAC_VEC_ENGINE_SAT_EN
        recv_d(pk_out(2147483647, 2147483647, 2147483647, 2147483647), 0, 1'b1);
`else
        recv_d(pk_out(-262140, -262140, -262140, -262140), 0, 1'b1);
`endif

        // 5: clear mid-accumulation, then a clean job
        start_job(3, 0, 1'b0);
        send_beat(pk_in(7, 7, 7, 7), pk_in(7, 7, 7, 7), 0);
        clear_i = 1'b1;
        @(negedge clk);
        clear_i = 1'b0;
        #1;
        check("t5_clr_busy", busy_o, 1'b0);
        check("t5_clr_cnt", cnt_o, 16'd0);
        start_job(1, 0, 1'b0);
        send_beat(pk_in(1, 1, 1, 1), pk_in(1, 1, 1, 1), 0);
        send_c(pk_out(1, 1, 1, 1));
        recv_d(pk_out(2, 2, 2, 2), 0, 1'b1);

        // 6: start while busy ignored, then empty mode-0 job
        start_job(1, 0, 1'b0);
        start_job(0, 0, 1'b1);
        #1;
        check("t6_busy", busy_o, 1'b1);
        check("t6_cnt", cnt_o, 16'd0);
        send_beat(pk_in(2, -3, 4, 5), pk_in(3, 3, 3, 3), 0);
        send_c(pk_out(1, 1, 1, 1));
        recv_d(pk_out(7, -8, 13, 16), 0, 1'b1);
        start_job(0, 0, 1'b0);
        #1;
        check("t6_bias_direct", c_ready_o, 1'b1);
        send_c(pk_out(-5, -5, -5, -5));
        recv_d(pk_out(-5, -5, -5, -5), 0, 1'b1);
        check("t6_idle", busy_o, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
